// File: rtl/addr_rr_arbiter_mux.sv
// =============================================================================
// Module  : addr_rr_arbiter_mux
// Brief   : Round-robin arbitrated, registered address mux toward one ICache
//           port with valid/ready output and a one-cycle ack to the winner.
//           Optional macro ADDR_MUX_PARITY_EN adds registered even parity.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module addr_rr_arbiter_mux #(
  parameter int NUM_CH = 32,
  parameter int AW     = 32,
  parameter int SELW   = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_CH-1:0]    inReq,
  input  logic [NUM_CH*AW-1:0] inAddr,
  output logic [NUM_CH-1:0]    inAck,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [AW-1:0]        outAddr,
  output logic [SELW-1:0]      outSel,
  output logic                 outPar
);

  localparam logic [SELW:0]   c_NUM_CH = (SELW+1)'(NUM_CH);
  localparam logic [SELW-1:0] c_LAST   = SELW'(NUM_CH-1);

  logic [SELW-1:0]     r_rrPtr;
  logic [SELW-1:0]     r_sel;
  logic [AW-1:0]       r_addr;
  logic                r_valid;
  logic [NUM_CH-1:0]   r_ack;

  logic [2*NUM_CH-1:0] w_dbl;
  logic [NUM_CH-1:0]   w_rot;
  logic                w_found;
  logic [SELW-1:0]     w_off;
  logic [SELW:0]       w_sum;
  logic [SELW-1:0]     w_winner;
  logic [AW-1:0]       w_winAddr;
  logic [NUM_CH-1:0]   w_ackVec;
  logic                w_load;

  // Rotate requests so bit 0 is the pointer position; lowest set bit wins.
  always_comb begin
    w_dbl   = {inReq, inReq} >> r_rrPtr;
    w_rot   = w_dbl[NUM_CH-1:0];
    w_found = 1'b0;
    w_off   = '0;
    for (int j = NUM_CH-1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_found = 1'b1;
        w_off   = SELW'(j);
      end
    end
    w_sum = {1'b0, r_rrPtr} + {1'b0, w_off};
    if (w_sum >= c_NUM_CH) begin
      w_sum = w_sum - c_NUM_CH;
    end
    w_winner = w_sum[SELW-1:0];
  end

  always_comb begin
    w_winAddr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (SELW'(i) == w_winner) begin
        w_winAddr = inAddr[i*AW +: AW];
      end
    end
  end

  assign w_ackVec = {{(NUM_CH-1){1'b0}}, 1'b1} << w_winner;
  assign w_load   = enable && w_found && (!r_valid || outReady);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rrPtr <= '0;
      r_sel   <= '0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_ack   <= '0;
    end else begin
      r_ack <= '0;
      if (w_load) begin
        r_addr  <= w_winAddr;
        r_sel   <= w_winner;
        r_valid <= 1'b1;
        r_ack   <= w_ackVec;
        r_rrPtr <= (w_winner == c_LAST) ? '0 : w_winner + 1'b1;
      end else if (r_valid && outReady) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef ADDR_MUX_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (w_load) begin
      r_par <= ^w_winAddr;
    end
  end

  assign outPar = r_par;
`else
  assign outPar = 1'b0;
`endif

  assign inAck    = r_ack;
  assign outValid = r_valid;
  assign outAddr  = r_addr;
  assign outSel   = r_sel;

endmodule

`default_nettype wire
